// File: rtl/hierarchy_pipe_pkg.sv
// Shared elaboration-test helpers for hierarchy_pipe.
// Width-generic extension to a wide vector; callers truncate.
package hierarchy_pipe_pkg;

  localparam int XW = 64;

  function automatic logic [XW-1:0] zext(
    input logic [XW-1:0] v,
    input int            w
  );
    return v & ~({XW{1'b1}} << w);
  endfunction

  function automatic logic [XW-1:0] sext(
    input logic [XW-1:0] v,
    input int            w
  );
    logic [XW-1:0] m;
    logic [XW-1:0] t;
    m = {XW{1'b1}} << w;
    t = v >> (w - 1);
    return t[0] ? (v | m) : (v & ~m);
  endfunction

endpackage

// File: rtl/hierarchy_pipe_stage.sv
// Generic W-bit valid/ready register slice.
// Loads whenever empty or its current beat is consumed.
module hierarchy_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/hierarchy_pipe.sv
// Two-stage pipelined xor / offset-add / chained-add / accumulate
// block behind a valid/ready stream.
module hierarchy_pipe
  import hierarchy_pipe_pkg::*;
#(
  parameter int              AW       = 4,
  parameter int              BW       = 4,
  parameter int              OW       = 8,
  parameter bit              B_SIGNED = 1'b1,
  parameter int              C        = -1,
  parameter logic [OW-1:0]   D        = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] a,
  input  logic [BW-1:0] b,
  input  logic          clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] y1,
  output logic [OW-1:0] y2,
  output logic [OW-1:0] y3,
  output logic [OW-1:0] y4
);

  localparam logic [OW-1:0] EC = OW'(sext(XW'(C), 32));

  logic [OW-1:0]   ea;
  logic [OW-1:0]   eb;
  logic [3*OW-1:0] s1_q;
  logic            s1_valid;
  logic            s2_ready;
  logic [OW-1:0]   s1_y1;
  logic [OW-1:0]   s1_y2;
  logic [OW-1:0]   s1_ea;
  logic [OW-1:0]   sum3;
  logic [OW-1:0]   acc;
  logic [OW-1:0]   acc_next;
  logic            s2_load;

  assign ea = OW'(zext(XW'(a), AW));
  assign eb = B_SIGNED ? OW'(sext(XW'(b), BW))
                       : OW'(zext(XW'(b), BW));

  hierarchy_pipe_stage #(.W(3*OW)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({ea ^ eb, eb + EC, ea}),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_q)
  );

  assign s1_y1 = s1_q[3*OW-1:2*OW];
  assign s1_y2 = s1_q[2*OW-1:OW];
  assign s1_ea = s1_q[OW-1:0];

  assign sum3     = s1_y2 + s1_ea;
  assign acc_next = (clr ? D : acc) + sum3;
  assign s2_load  = s1_valid && s2_ready;

  hierarchy_pipe_stage #(.W(4*OW)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   ({s1_y1, s1_y2, sum3, acc_next}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  ({y1, y2, y3, y4})
  );

  // Only a beat landing in stage 2 adds; a stalled beat never re-adds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= D;
    end else if (s2_load) begin
      acc <= acc_next;
    end else if (clr) begin
      acc <= D;
    end
  end

endmodule

// File: tb/tb_hierarchy_pipe.sv
// Scoreboard bench for hierarchy_pipe: default instance plus an
// unsigned-b / C=3 / D=0xF0 instance driven in lockstep.
module tb_hierarchy_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       clr;
  logic       out_ready;

  logic       r0, r1, v0, v1;
  wire [31:0] o0;
  wire [31:0] o1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [7:0]  acc0;
  logic [7:0]  acc1;

  always #5 clk = ~clk;

  hierarchy_pipe dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r0),
    .a(a), .b(b), .clr(clr), .out_valid(v0), .out_ready(out_ready),
    .y1(o0[31:24]), .y2(o0[23:16]), .y3(o0[15:8]), .y4(o0[7:0])
  );

  hierarchy_pipe #(
    .B_SIGNED(1'b0), .C(3), .D(8'hF0)
  ) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1),
    .a(a), .b(b), .clr(clr), .out_valid(v1), .out_ready(out_ready),
    .y1(o1[31:24]), .y2(o1[23:16]), .y3(o1[15:8]), .y4(o1[7:0])
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] calc(
    input logic [3:0] av, input logic [3:0] bv, input bit bs,
    input logic [7:0] c, input logic [7:0] d, input bit cf,
    input logic [7:0] acc
  );
    logic [7:0] ea, eb, e1, e2, e3, e4;
    ea = {4'b0, av};
    eb = bs ? {{4{bv[3]}}, bv} : {4'b0, bv};
    e1 = ea ^ eb;
    e2 = eb + c;
    e3 = e2 + ea;
    e4 = (cf ? d : acc) + e3;
    return {e1, e2, e3, e4};
  endfunction

  task automatic push(input logic [3:0] av, input logic [3:0] bv,
                      input bit cf);
    logic [31:0] e;
    e = calc(av, bv, 1'b1, 8'hFF, 8'h00, cf, acc0);
    q0.push_back(e);
    acc0 = e[7:0];
    e = calc(av, bv, 1'b0, 8'h03, 8'hF0, cf, acc1);
    q1.push_back(e);
    acc1 = e[7:0];
  endtask

  // cf: hold clr during the cycle this beat enters stage 2
  task automatic send(input logic [3:0] av, input logic [3:0] bv,
                      input bit cf);
    int t;
    t = 0;
    in_valid = 1'b1;
    a = av;
    b = bv;
    @(negedge clk);
    while (!r0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("accept_timeout", 32'(t < 50), 32'd1);
    push(av, bv, cf);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr = cf;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      clr = 1'b0;
    end
  endtask

  task automatic clr_alone();
    clr  = 1'b1;
    acc0 = 8'h00;
    acc1 = 8'hF0;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && v0 && out_ready) begin
      if (q0.size() == 0) check("unexpected0", 32'd1, 32'd0);
      else check("y_dut0", o0, q0.pop_front());
      if (q1.size() == 0) check("unexpected1", 32'd1, 32'd0);
      else check("y_dut1", o1, q1.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] snap;
    int          idx;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    clr = 1'b0;
    out_ready = 1'b1;
    acc0 = 8'h00;
    acc1 = 8'hF0;
    #12;
    check("rst_valid", {30'd0, v0, v1}, 32'd0);
    check("rst_ready", {30'd0, r0, r1}, 32'd3);
    check("rst_y0", o0, 32'd0);
    check("rst_y1", o1, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    send(4'd3, 4'b1110, 1'b0);
    check("lat_n", {31'd0, v0}, 32'd0);
    @(posedge clk);
    #1;
    check("lat_n1", {31'd0, v0}, 32'd1);
    check("first_beat", o0, 32'hFDFD_0000);
    idle(2);

    send(4'd5, 4'd2, 1'b0);
    send(4'd15, 4'd7, 1'b0);
    idle(3);

    send(4'd5, 4'd2, 1'b1);
    idle(4);
    clr_alone();
    send(4'd5, 4'd2, 1'b0);
    idle(4);

    out_ready = 1'b0;
    idx = 0;
    snap = '0;
    in_valid = 1'b1;
    a = 4'd1;
    b = 4'd0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c >= 2) check("bp_in_ready", {31'd0, r0}, 32'd0);
      if (c == 2) snap = o0;
      if (c > 2) check("bp_hold", o0, snap);
      if (c > 2) check("bp_valid", {31'd0, v0}, 32'd1);
      if (r0) begin
        push(a, b, 1'b0);
        idx++;
      end
      @(posedge clk);
      #1;
      a = 4'(idx + 1);
      b = 4'(idx * 3);
    end
    check("bp_accepts", 32'(idx), 32'd2);
    out_ready = 1'b1;
    while (idx < 5) begin
      send(4'(idx + 1), 4'(idx * 3), 1'b0);
      idx++;
    end
    idle(4);

    out_ready = 1'b0;
    send(4'd9, 4'd1, 1'b0);
    send(4'd10, 4'd2, 1'b0);
    idle(1);
    check("full_valid", {31'd0, v0}, 32'd1);
    check("full_ready", {31'd0, r0}, 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {30'd0, v0, v1}, 32'd0);
    check("mid_rst_ready", {30'd0, r0, r1}, 32'd3);
    check("mid_rst_y0", o0, 32'd0);
    check("mid_rst_y1", o1, 32'd0);
    q0.delete();
    q1.delete();
    acc0 = 8'h00;
    acc1 = 8'hF0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(4'd0, 4'd15, 1'b0);
    @(posedge clk);
    #1;
    check("wrap_dut1", o1, 32'h0F12_1202);
    idle(4);

    check("drain0", 32'(q0.size()), 32'd0);
    check("drain1", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
